led_stream_receiver: RTL and testbench

Receive-side counterpart of the LED strip driver: decodes the two-wire serial LED stream (`sclkIn`, `sdIn`) back into per-LED 24-bit RGB words and frame-boundary events. It sits on the test/loopback side of the design, so the driver's output can be checked in-system, and it can also forward a strip stream to a second chain. It oversamples the stream with the system clock, deserialises MSB-first 24-bit words, and detects the frame latch from clock idle time.

---
 rtl/led_stream_receiver_pkg.sv | 15 +
 rtl/led_stream_receiver_edge_sync.sv | 29 ++
 rtl/led_stream_receiver.sv | 131 +++++++++++++
 tb/tb_led_stream_receiver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/led_stream_receiver_pkg.sv
// rtl/led_stream_receiver_pkg.sv - shared types for the LED stream receiver
// RGB word type is shared with the driver side.
package led_stream_receiver_pkg;

  localparam int LED_BITS = 24;

  typedef logic [LED_BITS-1:0] rgb_t;

  typedef enum logic [1:0] {
    LR_IDLE  = 2'd0,
    LR_SHIFT = 2'd1,
    LR_LATCH = 2'd2
  } lr_state_t;

endpackage

// File: rtl/led_stream_receiver_edge_sync.sv
// rtl/led_stream_receiver_edge_sync.sv - two-flop synchroniser with rising-edge detect
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic meta;
  logic sync_q;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev;

endmodule

// File: rtl/led_stream_receiver.sv
// rtl/led_stream_receiver.sv - decodes the serial LED stream into RGB words and frame events
// Oversamples sclkIn/sdIn with clk; a long clock-idle gap marks the frame latch.
module led_stream_receiver
  import led_stream_receiver_pkg::*;
#(
  parameter int LEDS         = 50,
  parameter int FREQ         = 12_000_000,
  parameter int LATCH_CYCLES = 6000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclkIn,
  input  logic                       sdIn,
  output logic [LED_BITS-1:0]        rgb,
  output logic [$clog2(LEDS)-1:0]    ledIdx,
  output logic                       ledValid,
  output logic                       frameDone,
  output logic [$clog2(LEDS+1)-1:0]  ledCount,
  output logic                       frameErr,
  output logic                       overflow
);

  localparam int IDX_W  = $clog2(LEDS);
  localparam int CNT_W  = $clog2(LEDS + 1);
  localparam int WC_W   = $clog2(LEDS + 2);
  localparam int IDLE_W = $clog2(LATCH_CYCLES + 1);

  localparam logic [WC_W-1:0]   WC_LEDS   = WC_W'(LEDS);
  localparam logic [WC_W-1:0]   WC_MAX    = WC_W'(LEDS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LATCH_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(LATCH_CYCLES);
  localparam logic [4:0]        BIT_LAST  = 5'(LED_BITS - 1);
  localparam int                unused_freq_mhz = FREQ / 1_000_000;

  logic sclk_sync;
  logic edge_seen;
  logic d;
  logic sd_rise_unused;

  edge_sync u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclkIn),
    .sync (sclk_sync),
    .rise (edge_seen)
  );

  // Data uses the same synchroniser depth so it lines up with the edge detect.
  edge_sync u_sd_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sdIn),
    .sync (d),
    .rise (sd_rise_unused)
  );

  lr_state_t         state;
  rgb_t              shreg;
  logic [4:0]        bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LR_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      idle_cnt  <= '0;
      ovf       <= 1'b0;
      rgb       <= '0;
      ledIdx    <= '0;
      ledValid  <= 1'b0;
      frameDone <= 1'b0;
      ledCount  <= '0;
      frameErr  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ledValid  <= 1'b0;
      frameDone <= 1'b0;
      case (state)
        LR_IDLE: begin
          if (edge_seen) begin
            shreg    <= {shreg[LED_BITS-2:0], d};
            bit_cnt  <= 5'd1;
            idle_cnt <= '0;
            state    <= LR_SHIFT;
          end
        end
        LR_SHIFT: begin
          if (edge_seen) begin
            shreg    <= {shreg[LED_BITS-2:0], d};
            idle_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              rgb     <= {shreg[LED_BITS-2:0], d};
              if (word_cnt < WC_LEDS) begin
                ledValid <= 1'b1;
                ledIdx   <= word_cnt[IDX_W-1:0];
              end else begin
                ovf <= 1'b1;
              end
              if (word_cnt != WC_MAX) word_cnt <= word_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            if (idle_cnt == IDLE_LAST) begin
              state     <= LR_LATCH;
              frameDone <= 1'b1;
              ledCount  <= (word_cnt > WC_LEDS) ? CNT_W'(LEDS) : word_cnt[CNT_W-1:0];
              frameErr  <= (bit_cnt != 5'd0) | ovf;
              overflow  <= ovf;
            end
            if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
          end
        end
        LR_LATCH: begin
          // Any edge landing here is dropped; the partial word goes with it.
          state    <= LR_IDLE;
          word_cnt <= '0;
          bit_cnt  <= '0;
          ovf      <= 1'b0;
        end
        default: state <= LR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_stream_receiver.sv
// tb/tb_led_stream_receiver.sv - scoreboard bench for led_stream_receiver
module tb_led_stream_receiver;

  localparam int LEDS  = 50;
  localparam int LATCH = 6000;
  localparam int IDX_W = $clog2(LEDS);
  localparam int CNT_W = $clog2(LEDS + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sclkIn = 1'b0;
  logic              sdIn = 1'b0;
  logic [23:0]       rgb;
  logic [IDX_W-1:0]  ledIdx;
  logic              ledValid;
  logic              frameDone;
  logic [CNT_W-1:0]  ledCount;
  logic              frameErr;
  logic              overflow;

  always #5 clk = ~clk;

  led_stream_receiver #(
    .LEDS         (LEDS),
    .FREQ         (12_000_000),
    .LATCH_CYCLES (LATCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclkIn    (sclkIn),
    .sdIn      (sdIn),
    .rgb       (rgb),
    .ledIdx    (ledIdx),
    .ledValid  (ledValid),
    .frameDone (frameDone),
    .ledCount  (ledCount),
    .frameErr  (frameErr),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [23:0]      rgb;
    logic [IDX_W-1:0] idx;
  } led_exp_t;

  typedef struct {
    int count;
    bit err;
    bit ovf;
    bit timed;
  } frame_exp_t;

  led_exp_t   led_q[$];
  frame_exp_t frame_q[$];
  led_exp_t   e_led;
  frame_exp_t e_frm;
  int         cyc = 0;
  int         last_valid_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (ledValid) begin
        last_valid_cyc = cyc;
        if (led_q.size() == 0) begin
          check("unexpected_led_valid", ledValid, 0);
        end else begin
          e_led = led_q.pop_front();
          check("rgb", rgb, e_led.rgb);
          check("led_idx", ledIdx, e_led.idx);
        end
      end
      if (frameDone) begin
        check("valid_done_overlap", ledValid, 0);
        if (frame_q.size() == 0) begin
          check("unexpected_frame_done", frameDone, 0);
        end else begin
          e_frm = frame_q.pop_front();
          check("led_count", ledCount, e_frm.count);
          check("frame_err", frameErr, e_frm.err);
          check("overflow", overflow, e_frm.ovf);
          if (e_frm.timed) check("frame_done_latency", cyc - last_valid_cyc, LATCH);
        end
      end
    end
  end

  // One serial bit: low phase of low_cycles, then 6 cycles high (rise spacing = low_cycles + 6).
  task automatic send_bit(input logic b, input int low_cycles = 4);
    @(negedge clk);
    sdIn   = b;
    sclkIn = 1'b0;
    repeat (low_cycles) @(negedge clk);
    sclkIn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits = 24);
    for (int i = 0; i < nbits; i++) send_bit(w[23-i]);
  endtask

  task automatic expect_led(input logic [23:0] w, input int idx);
    led_q.push_back('{rgb: w, idx: IDX_W'(idx)});
  endtask

  task automatic expect_frame(input int count, input bit err, input bit ovf, input bit timed);
    frame_q.push_back('{count: count, err: err, ovf: ovf, timed: timed});
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_q.size() != 0 && n < LATCH + 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frame_pending"}, frame_q.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  logic [23:0] w;
  logic [7:0]  b8;

  initial begin
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rgb", rgb, 0);
    check("reset_led_idx", ledIdx, 0);
    check("reset_led_valid", ledValid, 0);
    check("reset_frame_done", frameDone, 0);
    check("reset_led_count", ledCount, 0);
    check("reset_frame_err", frameErr, 0);
    check("reset_overflow", overflow, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Reset mid-stream: the partial frame must vanish without a frameDone.
    send_word(24'hDEADBE, 10);
    @(negedge clk);
    sclkIn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    expect_led(24'h123456, 0);
    send_word(24'h123456);
    expect_frame(1, 0, 0, 1);
    wait_frame("reset_mid");

    // Single LED.
    expect_led(24'hFF8001, 0);
    send_word(24'hFF8001);
    expect_frame(1, 0, 0, 1);
    wait_frame("single");

    // Full frame.
    for (int i = 0; i < LEDS; i++) begin
      b8 = 8'(i);
      w  = {b8, ~b8, b8 ^ 8'h5A};
      expect_led(w, i);
      send_word(w);
    end
    expect_frame(LEDS, 0, 0, 1);
    wait_frame("full");

    // Overflow: two words beyond LEDS.
    for (int i = 0; i < LEDS + 2; i++) begin
      b8 = 8'(i + 7);
      w  = {~b8, b8, b8 ^ 8'hC3};
      if (i < LEDS) expect_led(w, i);
      send_word(w);
    end
    expect_frame(LEDS, 1, 1, 0);
    wait_frame("overflow");

    // Partial word, then a clean single-LED frame.
    expect_led(24'h0F1E2D, 0);
    send_word(24'h0F1E2D);
    expect_led(24'hA0B0C0, 1);
    send_word(24'hA0B0C0);
    send_word(24'hFFFFFF, 7);
    expect_frame(2, 1, 0, 0);
    wait_frame("partial");
    expect_led(24'h0055AA, 0);
    send_word(24'h0055AA);
    expect_frame(1, 0, 0, 1);
    wait_frame("after_partial");

    // Latch boundary: 5999 idle cycles mid-word keep the frame open.
    w = 24'hA5C30F;
    expect_led(w, 0);
    for (int i = 0; i < 24; i++) send_bit(w[23-i], (i == 12) ? (LATCH - 6) : 4);
    expect_frame(1, 0, 0, 1);
    wait_frame("latch_gap");

    check("leds_pending", led_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
